// File: rtl/cronometro_param.sv
// cronometro_param: parametrised time-of-day / stopwatch counter.
// Produces the 11-slot BCD digit bus (HH:MM:SS.CC with separator codes)
// for the 7-segment multiplexer, with prescaler, run/stop, clear, preset
// load and a lap function that freezes the display on a captured time.
module cronometro_param #(
    parameter int unsigned CLK_PER_CS = 100,
    parameter int unsigned HOUR_MAX   = 23,
    parameter logic [3:0]  SEP_CODE   = 4'd10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        clear,
    input  logic        load,
    input  logic [6:0]  load_h,
    input  logic [5:0]  load_m,
    input  logic [5:0]  load_s,
    input  logic        lap,
    output logic [43:0] num_data,
    output logic        lap_active,
    output logic        cs_tick,
    output logic        day_wrap
);

    localparam int unsigned PW = $clog2(CLK_PER_CS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_CS - 1);
    localparam logic [6:0] HOUR_LAST = 7'(HOUR_MAX);
    localparam logic [6:0] CS_LAST = 7'd99;
    localparam logic [5:0] SM_LAST = 6'd59;

    // Live time registers
    logic [PW-1:0] presc;
    logic [6:0]    cs;
    logic [5:0]    sec;
    logic [5:0]    mins;
    logic [6:0]    hs;

    // Lap (frozen) copies of the live time
    logic [6:0]    l_cs;
    logic [5:0]    l_sec;
    logic [5:0]    l_mins;
    logic [6:0]    l_hs;

    // Carry-chain terminal detections
    logic          cs_last;
    logic          sec_last;
    logic          min_last;
    logic          hs_last;

    // Clamped preset values
    logic [6:0]    hs_preset;
    logic [5:0]    min_preset;
    logic [5:0]    sec_preset;

    // Display source after lap selection
    logic [6:0]    d_cs;
    logic [6:0]    d_sec;
    logic [6:0]    d_min;
    logic [6:0]    d_hs;

    // Tens digit of a 0..99 value
    function automatic logic [3:0] tens_of(input logic [6:0] v);
        logic [6:0] q;
        q = v / 7'd10;
        return q[3:0];
    endfunction

    // Units digit of a 0..99 value
    function automatic logic [3:0] units_of(input logic [6:0] v);
        logic [6:0] r;
        r = v % 7'd10;
        return r[3:0];
    endfunction

    // Terminal-count flags, hundredth strobe and end-of-day strobe; clear and
    // load suppress the strobes because they override the advance on this edge
    always_comb begin
        cs_last  = (cs == CS_LAST);
        sec_last = (sec == SM_LAST);
        min_last = (mins == SM_LAST);
        hs_last  = (hs == HOUR_LAST);
        cs_tick  = run & ~clear & ~load & (presc == PRESC_LAST);
        day_wrap = cs_tick & cs_last & sec_last & min_last & hs_last;
    end

    // Preset values saturate at the largest legal value of each field
    always_comb begin
        hs_preset  = (load_h > HOUR_LAST) ? HOUR_LAST : load_h;
        min_preset = (load_m > SM_LAST) ? SM_LAST : load_m;
        sec_preset = (load_s > SM_LAST) ? SM_LAST : load_s;
    end

    // Prescaler: counts clock cycles within one hundredth; holds while stopped
    // so a resumed run finishes the interrupted hundredth without phase loss
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (clear || load) begin
            presc <= '0;
        end else if (run) begin
            if (presc == PRESC_LAST) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    // Live time: clear beats load beats counting; carries ripple cs->sec->min->hs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs   <= '0;
            sec  <= '0;
            mins <= '0;
            hs   <= '0;
        end else if (clear) begin
            cs   <= '0;
            sec  <= '0;
            mins <= '0;
            hs   <= '0;
        end else if (load) begin
            cs   <= '0;
            sec  <= sec_preset;
            mins <= min_preset;
            hs   <= hs_preset;
        end else if (cs_tick) begin
            if (!cs_last) begin
                cs <= cs + 7'd1;
            end else begin
                cs <= '0;
                if (!sec_last) begin
                    sec <= sec + 6'd1;
                end else begin
                    sec <= '0;
                    if (!min_last) begin
                        mins <= mins + 6'd1;
                    end else begin
                        mins <= '0;
                        hs   <= hs_last ? 7'd0 : hs + 7'd1;
                    end
                end
            end
        end
    end

    // Lap toggle: first pulse snapshots the pre-edge live time and freezes the
    // display, second pulse releases it; clear cancels everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_active <= 1'b0;
            l_cs       <= '0;
            l_sec      <= '0;
            l_mins     <= '0;
            l_hs       <= '0;
        end else if (clear) begin
            lap_active <= 1'b0;
            l_cs       <= '0;
            l_sec      <= '0;
            l_mins     <= '0;
            l_hs       <= '0;
        end else if (lap) begin
            if (lap_active) begin
                lap_active <= 1'b0;
            end else begin
                lap_active <= 1'b1;
                l_cs       <= cs;
                l_sec      <= sec;
                l_mins     <= mins;
                l_hs       <= hs;
            end
        end
    end

    // Select the frozen copy or the live time for display
    always_comb begin
        d_cs  = lap_active ? l_cs : cs;
        d_sec = lap_active ? {1'b0, l_sec} : {1'b0, sec};
        d_min = lap_active ? {1'b0, l_mins} : {1'b0, mins};
        d_hs  = lap_active ? l_hs : hs;
    end

    // Pack digits into slots; slot 0 (hours tens) sits in the low nibble
    always_comb begin
        num_data = {units_of(d_cs),  tens_of(d_cs),  SEP_CODE,
                    units_of(d_sec), tens_of(d_sec), SEP_CODE,
                    units_of(d_min), tens_of(d_min), SEP_CODE,
                    units_of(d_hs),  tens_of(d_hs)};
    end

endmodule

// File: tb/tb_cronometro_param.sv
// tb_cronometro_param: directed and random stimulus for cronometro_param,
// checked every cycle against a time-in-hundredths reference model.
module tb_cronometro_param;

    localparam int N = 4;
    localparam int HM = 23;
    localparam logic [3:0] SEP = 4'd10;
    localparam int DAY = (HM + 1) * 360000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        clear = 1'b0;
    logic        load = 1'b0;
    logic        lap = 1'b0;
    logic [6:0]  load_h = '0;
    logic [5:0]  load_m = '0;
    logic [5:0]  load_s = '0;
    logic [43:0] num_data;
    logic        lap_active;
    logic        cs_tick;
    logic        day_wrap;

    int vectors = 0;
    int miscompares = 0;
    bit armed = 1'b0;

    int mT = 0;
    int mPresc = 0;
    int mLapT = 0;
    bit mLap = 1'b0;

    logic sCsTick;
    logic sDayWrap;
    int   wraps;

    cronometro_param #(
        .CLK_PER_CS(N),
        .HOUR_MAX(HM),
        .SEP_CODE(SEP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .run(run),
        .clear(clear),
        .load(load),
        .load_h(load_h),
        .load_m(load_m),
        .load_s(load_s),
        .lap(lap),
        .num_data(num_data),
        .lap_active(lap_active),
        .cs_tick(cs_tick),
        .day_wrap(day_wrap)
    );

    always #5 clk = ~clk;

    // Display word for a time given as hundredths since midnight
    function automatic logic [43:0] disp(input int t);
        int h, m, s, c;
        h = t / 360000;
        m = (t / 6000) % 60;
        s = (t / 100) % 60;
        c = t % 100;
        return {4'(c % 10), 4'(c / 10), SEP, 4'(s % 10), 4'(s / 10), SEP,
                4'(m % 10), 4'(m / 10), SEP, 4'(h % 10), 4'(h / 10)};
    endfunction

    task automatic checkOutput(input string name, input logic [43:0] act, input logic [43:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit c, input bit ld, input bit lp,
                                 input logic [6:0] h, input logic [5:0] m, input logic [5:0] s);
        run = r;
        clear = c;
        load = ld;
        lap = lp;
        load_h = h;
        load_m = m;
        load_s = s;
        #1;
        sCsTick = cs_tick;
        sDayWrap = day_wrap;
        @(posedge clk);
        #1;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 6'd0, 6'd0);
    endtask

    // Reference model: time kept as one integer of hundredths modulo a day
    always @(posedge clk or negedge rst_n) begin
        int nt, np, nlt;
        bit nl;
        if (!rst_n) begin
            mT <= 0;
            mPresc <= 0;
            mLap <= 1'b0;
            mLapT <= 0;
        end else begin
            nt = mT;
            np = mPresc;
            nl = mLap;
            nlt = mLapT;
            if (clear) begin
                nt = 0;
                np = 0;
                nl = 1'b0;
                nlt = 0;
            end else begin
                if (lap) begin
                    if (mLap) nl = 1'b0;
                    else begin
                        nl = 1'b1;
                        nlt = mT;
                    end
                end
                if (load) begin
                    nt = ((int'(load_h) > HM) ? HM : int'(load_h)) * 360000
                       + ((int'(load_m) > 59) ? 59 : int'(load_m)) * 6000
                       + ((int'(load_s) > 59) ? 59 : int'(load_s)) * 100;
                    np = 0;
                end else if (run) begin
                    if (mPresc == N - 1) begin
                        np = 0;
                        nt = (mT + 1) % DAY;
                    end else begin
                        np = mPresc + 1;
                    end
                end
            end
            mT <= nt;
            mPresc <= np;
            mLap <= nl;
            mLapT <= nlt;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        logic expTick;
        if (armed) begin
            expTick = run && !clear && !load && (mPresc == N - 1);
            checkOutput("num_data", num_data, disp(mLap ? mLapT : mT));
            checkOutput("lap_active", 44'(lap_active), 44'(mLap));
            checkOutput("cs_tick", 44'(cs_tick), 44'(expTick));
            checkOutput("day_wrap", 44'(day_wrap), 44'(expTick && (mT == DAY - 1)));
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        armed = 1'b1;
        checkOutput("reset_num_data", num_data, 44'h00A00A00A00);
        checkOutput("reset_lap_active", 44'(lap_active), 44'd0);
        checkOutput("reset_cs_tick", 44'(cs_tick), 44'd0);
        checkOutput("reset_day_wrap", 44'(day_wrap), 44'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] first hundredth after %0d edges", N);
        runCycles(3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 6'd0, 6'd0);
        checkOutput("tick_cycle4", 44'(sCsTick), 44'd1);
        checkOutput("cs_after_4", num_data, 44'h10A00A00A00);
        runCycles(396);
        checkOutput("after_400", num_data, 44'h00A10A00A00);

        $display("[TB] day wrap and preset clamp");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 7'd23, 6'd59, 6'd59);
        checkOutput("load_235959", num_data, 44'h00A95A95A32);
        wraps = 0;
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 6'd0, 6'd0);
            wraps += int'(sDayWrap);
        end
        checkOutput("day_wrap_count", 44'(wraps), 44'd1);
        checkOutput("after_wrap", num_data, 44'h00A00A00A00);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 7'd40, 6'd63, 6'd0);
        checkOutput("load_clamped", num_data, 44'h00A00A95A32);

        $display("[TB] run pause keeps prescaler phase");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 6'd0, 6'd0);
        runCycles(2);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 6'd0, 6'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 6'd0, 6'd0);
        checkOutput("resume_edge1", num_data, 44'h00A00A00A00);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 6'd0, 6'd0);
        checkOutput("resume_edge2", num_data, 44'h10A00A00A00);

        $display("[TB] lap freeze and release");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 7'd0, 6'd0, 6'd5);
        runCycles(148);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 7'd0, 6'd0, 6'd0);
        checkOutput("lap_capture", num_data, 44'h73A50A00A00);
        checkOutput("lap_set", 44'(lap_active), 44'd1);
        runCycles(651);
        checkOutput("lap_frozen", num_data, 44'h73A50A00A00);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 7'd0, 6'd0, 6'd0);
        checkOutput("lap_release", num_data, 44'h00A70A00A00);
        checkOutput("lap_cleared", 44'(lap_active), 44'd0);

        $display("[TB] clear with tick and lap");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 7'd0, 6'd0, 6'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 6'd0, 6'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 7'd0, 6'd0, 6'd0);
        checkOutput("tick_forced_low", 44'(sCsTick), 44'd0);
        checkOutput("clear_display", num_data, 44'h00A00A00A00);
        checkOutput("clear_lap", 44'(lap_active), 44'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 6'd0, 6'd0);
        checkOutput("no_advance_after_clear", num_data, 44'h00A00A00A00);

        $display("[TB] asynchronous reset while lap active");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 7'd0, 6'd0, 6'd0);
        lap = 1'b0;
        runCycles(40);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_num_data", num_data, 44'h00A00A00A00);
        checkOutput("async_lap_active", 44'(lap_active), 44'd0);
        checkOutput("async_cs_tick", 44'(cs_tick), 44'd0);
        checkOutput("async_day_wrap", 44'(day_wrap), 44'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] random stimulus");
        for (int i = 0; i < 3000; i++) begin
            bit r, c, ld, lp;
            logic [6:0] h;
            logic [5:0] m, s;
            r  = ($urandom_range(0, 7) != 0);
            c  = ($urandom_range(0, 63) == 0);
            ld = ($urandom_range(0, 31) == 0);
            lp = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 1) == 1) begin
                h = 7'($urandom_range(22, 127));
                m = 6'($urandom_range(58, 63));
                s = 6'($urandom_range(57, 63));
            end else begin
                h = 7'($urandom_range(0, 127));
                m = 6'($urandom_range(0, 63));
                s = 6'($urandom_range(0, 63));
            end
            applyStimulus(r, c, ld, lp, h, m, s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
